// File: rtl/gp_regfile.sv
// Register file with the PC in slot 0, three combinational read ports, two write
// ports and an in-order load scoreboard that flags read-after-load hazards.
module gp_regfile #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NREGS    = 16,
  parameter int unsigned RESET_PC = 16,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned LD_DEPTH = 4,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rc,
  input  logic [2:0]       re,
  output logic [WIDTH-1:0] rd_a,
  output logic [WIDTH-1:0] rd_b,
  output logic [WIDTH-1:0] rd_c,
  input  logic             pc_visible,
  output logic [WIDTH-1:0] pc,
  input  logic             pc_inc,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [WIDTH-1:0] wd1,
  input  logic             we2,
  input  logic [AW-1:0]    wa2,
  input  logic [WIDTH-1:0] wd2,
  input  logic             ld_issue,
  input  logic [AW-1:0]    ld_dst,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  output logic             ld_err,
  output logic [NREGS-1:0] pending,
  output logic             stall
);

  localparam int unsigned PW = $clog2(LD_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;
  logic [AW-1:0]    fifo_q [LD_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ld_err_q, ld_err_d;

  logic          fifo_full, fifo_empty, pop, push;
  logic [AW-1:0] head_tag;

  assign fifo_full  = (cnt_q == CW'(LD_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign head_tag   = fifo_q[rd_ptr_q];
  assign pop        = ld_valid && !fifo_empty;
  // pending is checked on registered state; a same-cycle pop makes room when full
  assign push       = ld_issue && (ld_dst != '0) && !pending_q[ld_dst] &&
                      (!fifo_full || ld_valid);

  assign ld_ready = !reset && (!fifo_full || ld_valid);
  assign ld_err   = ld_err_q;
  assign pending  = pending_q;
  assign pc       = regs_q[0];

  assign rd_a = (ra == '0) ? (pc_visible ? regs_q[0] : '0) : regs_q[ra];
  assign rd_b = (rb == '0) ? (pc_visible ? regs_q[0] : '0) : regs_q[rb];
  assign rd_c = (rc == '0) ? (pc_visible ? regs_q[0] : '0) : regs_q[rc];

  assign stall = (re[0] & pending_q[ra]) | (re[1] & pending_q[rb]) |
                 (re[2] & pending_q[rc]);

  // Per-register write select: port 1, port 2, load return, then PC increment
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we1 && (wa1 == AW'(i)))
        regs_d[i] = wd1;
      else if (we2 && (wa2 == AW'(i)))
        regs_d[i] = wd2;
      else if (pop && (head_tag == AW'(i)))
        regs_d[i] = ld_data;
      else if ((i == 0) && pc_inc)
        regs_d[i] = regs_q[i] + WIDTH'(PC_STEP);
    end
  end

  always_comb begin
    pending_d = pending_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ld_err_d  = (ld_issue && !push) || (ld_valid && fifo_empty);
    if (pop) begin
      pending_d[head_tag] = 1'b0;
      rd_ptr_d            = rd_ptr_q + PW'(1);
    end
    if (push) begin
      pending_d[ld_dst] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (push && !pop)
      cnt_d = cnt_q + CW'(1);
    else if (pop && !push)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= (i == 0) ? WIDTH'(RESET_PC) : '0;
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ld_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= regs_d[i];
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ld_err_q  <= ld_err_d;
    end
  end

  // Tag storage needs no reset: only slots between the pointers are ever read
  always_ff @(posedge clk) begin
    if (!reset && push)
      fifo_q[wr_ptr_q] <= ld_dst;
  end

endmodule

// File: tb/tb_gp_regfile.sv
// Directed and random checks of gp_regfile against a queue-based scoreboard model.
module tb_gp_regfile;

  localparam int unsigned W = 32;
  localparam int unsigned N = 16;
  localparam int unsigned A = 4;
  localparam int unsigned D = 4;

  logic          clk, reset;
  logic [A-1:0]  ra, rb, rc;
  logic [2:0]    re;
  logic [W-1:0]  rd_a, rd_b, rd_c, pc;
  logic          pc_visible, pc_inc;
  logic          we1, we2;
  logic [A-1:0]  wa1, wa2;
  logic [W-1:0]  wd1, wd2;
  logic          ld_issue, ld_valid, ld_ready, ld_err, stall;
  logic [A-1:0]  ld_dst;
  logic [W-1:0]  ld_data;
  logic [N-1:0]  pending;

  gp_regfile #(.WIDTH(W), .NREGS(N), .RESET_PC(16), .PC_STEP(1), .LD_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rb(rb), .rc(rc), .re(re),
    .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c), .pc_visible(pc_visible), .pc(pc),
    .pc_inc(pc_inc), .we1(we1), .wa1(wa1), .wd1(wd1), .we2(we2), .wa2(wa2),
    .wd2(wd2), .ld_issue(ld_issue), .ld_dst(ld_dst), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .ld_err(ld_err), .pending(pending),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: architectural registers, pending flags, queue of load tags
  logic [W-1:0] m_regs [N];
  bit           m_pend [N];
  int           m_q [$];
  bit           m_err;
  bit           m_valid = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_read(input int a);
    if (a == 0) return pc_visible ? m_regs[0] : '0;
    return m_regs[a];
  endfunction

  function automatic logic [N-1:0] m_pvec();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic m_check();
    logic exp_stall, exp_ready;
    exp_stall = (re[0] && m_pend[ra]) || (re[1] && m_pend[rb]) || (re[2] && m_pend[rc]);
    exp_ready = !reset && (m_q.size() < D || ld_valid);
    chk("pc", pc, m_regs[0]);
    chk("rd_a", rd_a, m_read(int'(ra)));
    chk("rd_b", rd_b, m_read(int'(rb)));
    chk("rd_c", rd_c, m_read(int'(rc)));
    chk("pending", W'(pending), W'(m_pvec()));
    chk("stall", W'(stall), W'(exp_stall));
    chk("ld_ready", W'(ld_ready), W'(exp_ready));
    chk("ld_err", W'(ld_err), W'(m_err));
  endtask

  task automatic m_update();
    logic [W-1:0] nr [N];
    bit accept, popped;
    int tag;
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
      m_regs[0] = 16;
      m_q.delete();
      m_err = 0;
      m_valid = 1'b1;
      return;
    end
    for (int i = 0; i < N; i++) nr[i] = m_regs[i];
    accept = ld_issue && ld_dst != 0 && !m_pend[ld_dst] && (m_q.size() < D || ld_valid);
    m_err  = (ld_issue && !accept) || (ld_valid && m_q.size() == 0);
    popped = 0;
    tag    = -1;
    if (ld_valid && m_q.size() > 0) begin
      tag = m_q.pop_front();
      popped = 1;
      m_pend[tag] = 0;
      if (!(we1 && int'(wa1) == tag) && !(we2 && int'(wa2) == tag)) nr[tag] = ld_data;
    end
    if (we2) nr[wa2] = wd2;
    if (we1) nr[wa1] = wd1;
    if (pc_inc && !(we1 && wa1 == 0) && !(we2 && wa2 == 0) && !(popped && tag == 0))
      nr[0] = m_regs[0] + 1;
    if (accept) begin m_q.push_back(int'(ld_dst)); m_pend[ld_dst] = 1; end
    for (int i = 0; i < N; i++) m_regs[i] = nr[i];
  endtask

  // Check outputs mid-cycle, then advance DUT and model together
  task automatic cycle();
    @(negedge clk);
    if (m_valid) m_check();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle();
    we1 = 0; we2 = 0; ld_issue = 0; ld_valid = 0; pc_inc = 0; re = 3'b000;
  endtask

  initial begin
    reset = 1; ra = 0; rb = 0; rc = 0; pc_visible = 1;
    wa1 = 0; wa2 = 0; wd1 = 0; wd2 = 0; ld_dst = 0; ld_data = 0;
    idle();
    #1;
    cycle(); cycle();
    reset = 0;
    chk("rst_pc", pc, 16);
    chk("rst_pend", W'(pending), 0);
    chk("rst_err", W'(ld_err), 0);

    pc_inc = 1;
    repeat (3) cycle();
    pc_inc = 0;
    chk("pc19", pc, 19);
    ra = 0; pc_visible = 0; #1;
    chk("r0_hidden", rd_a, 0);
    pc_visible = 1; #1;
    chk("r0_visible", rd_a, 19);

    we1 = 1; wa1 = 5; wd1 = 32'hAAAA; we2 = 1; wa2 = 5; wd2 = 32'hBBBB;
    cycle();
    idle(); rb = 5; #1;
    chk("wr_prio", rd_b, 32'hAAAA);
    we1 = 1; wa1 = 0; wd1 = 100; pc_inc = 1;
    cycle();
    idle();
    chk("jump", pc, 100);

    foreach (m_regs[i]) begin end
    ld_issue = 1;
    ld_dst = 3; cycle();
    ld_dst = 4; cycle();
    ld_dst = 6; cycle();
    ld_dst = 7; cycle();
    chk("pend_full", W'(pending), 32'h00D8);
    ld_dst = 8; #1;
    chk("ready_full", W'(ld_ready), 0);
    cycle();
    idle();
    chk("err_full", W'(ld_err), 1);
    ld_valid = 1;
    ld_data = 32'h11; cycle();
    ld_data = 32'h22; cycle();
    ld_data = 32'h33; cycle();
    ld_data = 32'h44; cycle();
    idle();
    ra = 3; rb = 4; rc = 6; #1;
    chk("ret_r3", rd_a, 32'h11);
    chk("ret_r4", rd_b, 32'h22);
    chk("ret_r6", rd_c, 32'h33);
    ra = 7; #1;
    chk("ret_r7", rd_a, 32'h44);
    chk("pend_clr", W'(pending), 0);

    ld_issue = 1; ld_dst = 9; ra = 9; re = 3'b001; #1;
    chk("stall_issue", W'(stall), 0);
    cycle();
    ld_issue = 0; #1;
    chk("stall_next", W'(stall), 1);
    cycle();
    ld_valid = 1; ld_data = 32'h55;
    cycle();
    ld_valid = 0; #1;
    chk("stall_clr", W'(stall), 0);
    chk("r9", rd_a, 32'h55);
    idle();

    ld_issue = 1; ld_dst = 0; cycle(); idle();
    chk("err_r0", W'(ld_err), 1);
    chk("r0_nopend", W'(pending), 0);
    ld_issue = 1; ld_dst = 3; cycle(); cycle(); idle();
    chk("err_dup", W'(ld_err), 1);
    chk("dup_pend", W'(pending), 32'h0008);
    ld_valid = 1; ld_data = 32'h99; cycle(); idle();
    ld_valid = 1; cycle(); idle();
    chk("err_stray", W'(ld_err), 1);
    cycle();
    chk("err_oneshot", W'(ld_err), 0);

    ld_issue = 1; ld_dst = 2; cycle(); idle();
    reset = 1; cycle(); reset = 0;
    ld_valid = 1; ld_data = 32'h77; cycle(); idle();
    ra = 2; #1;
    chk("rst_r2", rd_a, 0);
    chk("rst_pend2", W'(pending), 0);
    chk("rst_pc2", pc, 16);
    chk("rst_stray", W'(ld_err), 1);

    for (int k = 0; k < 600; k++) begin
      reset      = ($urandom_range(0, 99) == 0);
      ra         = A'($urandom); rb = A'($urandom); rc = A'($urandom);
      re         = 3'($urandom);
      pc_visible = 1'($urandom);
      pc_inc     = 1'($urandom);
      we1        = ($urandom_range(0, 3) == 0); wa1 = A'($urandom); wd1 = $urandom;
      we2        = ($urandom_range(0, 3) == 0); wa2 = A'($urandom); wd2 = $urandom;
      ld_issue   = ($urandom_range(0, 1) == 0); ld_dst = A'($urandom_range(0, 7));
      ld_valid   = ($urandom_range(0, 2) == 0); ld_data = $urandom;
      cycle();
    end
    reset = 0;
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gp_regfile.md
# gp_regfile

Parametrised general-purpose register file with an embedded program counter and an in-order load scoreboard. It is the next-generation register bank for the core datapath. Register 0 is the PC; the remaining registers are general purpose. The block provides three combinational read ports and two ALU write ports. A tag FIFO tracks outstanding memory loads, and the block raises a hazard stall when an instruction reads a register whose load has not yet returned.

## Interface
- WIDTH, 32, register and data width in bits.
- NREGS, 16, number of registers including PC; power of two, at least 4.
- AW, $clog2(NREGS), register address width (derived; do not override).
- RESET_PC, 16, value loaded into the PC on reset.
- PC_STEP, 1, amount added to the PC per pc_inc.
- LD_DEPTH, 4, maximum outstanding loads; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ra, rb, rc  in  AW each  read addresses.
- re  in  3  read enables for ra/rb/rc (bit 0 = ra); used only for the hazard check.
- rd_a, rd_b, rd_c  out  WIDTH each  read data.
- pc_visible  in  1  when 1, reading address 0 returns the PC; when 0, it returns 0.
- pc  out  WIDTH  current PC.
- pc_inc  in  1  advance the PC by PC_STEP.
- we1, wa1, wd1  in  1/AW/WIDTH  write port 1 (highest priority).
- we2, wa2, wd2  in  1/AW/WIDTH  write port 2.
- ld_issue, ld_dst  in  1/AW  request a load into ld_dst.
- ld_valid, ld_data  in  1/WIDTH  in-order load return from memory.
- ld_ready  out  1  an issue is accepted this cycle.
- ld_err  out  1  registered one-cycle pulse flagging a rejected issue or a stray return.
- pending  out  NREGS  per-register outstanding-load bits.
- stall  out  1  read hazard on a pending register.

## Operation
- Reads are combinational from registered state, with no write bypass.
  - Address 0 reads the PC if pc_visible is 1, else 0.
- Writes, per clock edge, have the following priority for each register:
  - Port 1 has highest priority, then port 2, then load return.
  - A write to address 0 from any source loads the PC (jump). It overrides pc_inc for that cycle.
  - If no write targets address 0 and pc_inc is 1, the PC becomes PC + PC_STEP, wrapping modulo 2^WIDTH.
- Load issue:
  - An issue is accepted iff all of the following hold:
    - ld_dst is not 0.
    - pending[ld_dst] is 0, evaluated on registered state before any same-cycle clear.
    - The FIFO is not full, or ld_valid is 1 in the same cycle.
  - On acceptance, ld_dst is pushed into the tag FIFO and pending[ld_dst] is set.
  - On rejection, nothing changes and ld_err pulses the next cycle.
- Load return:
  - If ld_valid is 1 and the FIFO is non-empty:
    - Pop the head tag and clear pending[tag].
    - Write ld_data to that register unless a port-1 or port-2 write targets the same register in that cycle. In that case the load data is discarded and the pending bit is still cleared.
  - If ld_valid is 1 and the FIFO is empty, the return is dropped and ld_err pulses.
- Port 1 or port 2 writes to a pending register are legal. They write the register, and the pending bit stays set until the return.
- stall = OR over ports p of (re[p] and pending[addr_p]), using registered pending bits. A load issued in cycle t causes no stall in cycle t.
- ld_ready = reset is 0 and (FIFO not full or ld_valid is 1). ld_ready does not depend on ld_dst.
- Reset:
  - PC = RESET_PC and all other registers = 0.
  - pending, FIFO pointers and count are cleared; ld_err = 0.
  - Reset overrides every write, issue and return in the same cycle.
  - A return arriving after reset for a pre-reset load is a stray return: it is dropped and ld_err pulses.

## Timing
- Read latency is 0 (combinational). A write at edge t is visible on the read ports after edge t.
- Issue in cycle t: pending is set and visible after edge t, so stall can assert from cycle t+1.
- Return in cycle t: data is written and pending cleared at edge t. stall deasserts in cycle t+1 if no other hazard.
- ld_err is asserted for exactly the cycle after the offending event.
- FIFO count stays in the range 0..LD_DEPTH. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo LD_DEPTH.

## Test plan
- Reset, then hold pc_inc for 3 cycles → pc = 19. Read address 0 with pc_visible = 0 → 0. Read with pc_visible = 1 → 19.
- In one cycle, we1 with wa1 = 5, wd1 = 0xAAAA and we2 with wa2 = 5, wd2 = 0xBBBB → r5 = 0xAAAA. Then wa1 = 0, wd1 = 100 together with pc_inc → pc = 100.
- Issue loads to r3, r4, r6 and r7, then a fifth issue to r8 → ld_ready = 0 and ld_err pulses.
  - Returns 0x11, 0x22, 0x33, 0x44 land in r3, r4, r6, r7 in that order.
  - pending goes 0x00D8 → 0x0000.
- Issue a load to r9 and read with ra = 9, re = 001 → stall = 0 in the issue cycle and 1 from the next cycle. Return 0x55 → r9 = 0x55 and stall = 0 the cycle after.
- Each of the following pulses ld_err once and leaves state unchanged:
  - Issue to r0.
  - Issue to r3 while r3 is pending.
  - ld_valid with an empty FIFO.
- Issue a load to r2, reset for 1 cycle, then return 0x77 → r2 = 0, pending = 0, pc = 16, ld_err pulses.
